// File: rtl/ibuf_filt_rx_pkg.sv
// Shared constants and parameter checks for the pad receive filter family.
package ibuf_filt_rx_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned ICNT_W = clog2(256);
  localparam int unsigned BCNT_W = 3;

  function automatic bit params_ok(input int unsigned filter_len,
                                   input int unsigned idle_cycles,
                                   input int unsigned blank_tail);
    return (filter_len >= 1) && (filter_len <= 15) &&
           (idle_cycles >= 1) && (idle_cycles <= 255) &&
           (blank_tail <= 7);
  endfunction

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser into the C domain with clock enable and settable reset value.
module sync2_ff #(
  parameter logic INIT = 1'b0
) (
  input  logic c,
  input  logic r,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge c) begin
    if (r) begin
      s1 <= INIT;
      q  <= INIT;
    end else if (ce) begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ibuf_filt_rx.sv
// Pad receiver: synchronise, glitch-filter, edge strobes, idle detect, and echo blanking
// while the local tri-state driver owns the line.
module ibuf_filt_rx
  import ibuf_filt_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned BLANK_TAIL  = 2,
  parameter logic        INIT        = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic I,
  input  logic T_LOCAL,
  output logic O,
  output logic O_RISE,
  output logic O_FALL,
  output logic IDLE
);

  if (!params_ok(FILTER_LEN, IDLE_CYCLES, BLANK_TAIL)) begin : g_bad_param
    $error("ibuf_filt_rx: parameter out of legal range");
  end

  localparam logic [FCNT_W-1:0] FLEN  = FCNT_W'(FILTER_LEN);
  localparam logic [ICNT_W-1:0] ICYC  = ICNT_W'(IDLE_CYCLES);
  localparam logic [BCNT_W-1:0] BTAIL = BCNT_W'(BLANK_TAIL);

  logic              s2;
  logic [FCNT_W-1:0] fcnt;
  logic [ICNT_W-1:0] icnt;
  logic [BCNT_W-1:0] bcnt;

  logic              blanked_c;
  logic              differs_c;
  logic              flip_c;
  logic [ICNT_W-1:0] icnt_nxt_c;

  sync2_ff #(.INIT(INIT)) u_sync (
    .c  (C),
    .r  (R),
    .ce (CE),
    .d  (I),
    .q  (s2)
  );

  always_comb begin
    blanked_c  = !T_LOCAL || (bcnt != '0);
    differs_c  = (s2 != O);
    flip_c     = !blanked_c && differs_c && ((fcnt + FCNT_W'(1)) == FLEN);
    icnt_nxt_c = (icnt == ICYC) ? icnt : icnt + ICNT_W'(1);
  end

  // Priority: reset, then clock enable, then blanking, then filter, then idle count.
  always_ff @(posedge C) begin
    if (R) begin
      O      <= INIT;
      O_RISE <= 1'b0;
      O_FALL <= 1'b0;
      IDLE   <= 1'b0;
      fcnt   <= '0;
      icnt   <= '0;
      bcnt   <= '0;
    end else if (!CE) begin
      O_RISE <= 1'b0;
      O_FALL <= 1'b0;
    end else begin
      O_RISE <= 1'b0;
      O_FALL <= 1'b0;

      if (!T_LOCAL) begin
        bcnt <= BTAIL;
      end else if (bcnt != '0) begin
        bcnt <= bcnt - BCNT_W'(1);
      end

      if (blanked_c) begin
        fcnt <= '0;
        icnt <= '0;
        IDLE <= 1'b0;
      end else if (flip_c) begin
        O      <= s2;
        O_RISE <= s2;
        O_FALL <= !s2;
        fcnt   <= '0;
        icnt   <= '0;
        IDLE   <= 1'b0;
      end else begin
        fcnt <= differs_c ? fcnt + FCNT_W'(1) : '0;
        icnt <= icnt_nxt_c;
        IDLE <= (icnt_nxt_c == ICYC);
      end
    end
  end

endmodule

// File: tb/tb_ibuf_filt_rx.sv
// Directed bench for ibuf_filt_rx at default parameters; expected {O,O_RISE,O_FALL,IDLE}
// per edge are queued with the stimulus and checked just after that edge.
module tb_ibuf_filt_rx;

  logic C = 1'b0;
  logic R, CE, I, T_LOCAL;
  logic O, O_RISE, O_FALL, IDLE;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  localparam logic [3:0] Q0   = 4'b0000;
  localparam logic [3:0] Q1   = 4'b1000;
  localparam logic [3:0] Q1I  = 4'b1001;
  localparam logic [3:0] RISE = 4'b1100;
  localparam logic [3:0] FALL = 4'b0010;

  ibuf_filt_rx dut (
    .C       (C),
    .R       (R),
    .CE      (CE),
    .I       (I),
    .T_LOCAL (T_LOCAL),
    .O       (O),
    .O_RISE  (O_RISE),
    .O_FALL  (O_FALL),
    .IDLE    (IDLE)
  );

  always #5 C = ~C;

  task automatic check_one();
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    string      tag_v;
    exp_v = exp_q.pop_front();
    tag_v = tag_q.pop_front();
    obs_v = {O, O_RISE, O_FALL, IDLE};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s: observed {O,RISE,FALL,IDLE}=%b expected=%b at %0t", tag_v, obs_v, exp_v, $time);
    end
  endtask

  task automatic step(input logic i_v, input logic t_v, input logic ce_v, input logic r_v,
                      input logic [3:0] exp_v, input string tag);
    I       = i_v;
    T_LOCAL = t_v;
    CE      = ce_v;
    R       = r_v;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(posedge C);
    #1;
    check_one();
  endtask

  initial begin
    R = 1'b1; CE = 1'b1; I = 1'b0; T_LOCAL = 1'b1;
    #2;

    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, Q0, "reset");

    // I rises before edge 0: O must appear at edge FILTER_LEN+1 = 5
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q0, "lat_wait");
    step(1'b1, 1'b1, 1'b1, 1'b0, RISE, "lat_rise");

    for (int k = 1; k <= 19; k++) step(1'b1, 1'b1, 1'b1, 1'b0, (k >= 16) ? Q1I : Q1, "idle_count");

    // 3-sample low glitch on a high line: no change, idle stays saturated
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, Q1I, "glitch_lo");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q1I, "glitch_lo_after");

    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, Q1I, "fall_wait");
    step(1'b0, 1'b1, 1'b1, 1'b0, FALL, "fall_idle_clr");
    step(1'b0, 1'b1, 1'b1, 1'b0, Q0, "fall_hold");

    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q0, "glitch_hi");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, Q0, "glitch_hi_after");

    // 4-sample pulse passes the filter, then the trailing low passes too
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q0, "pulse4_wait");
    step(1'b0, 1'b1, 1'b1, 1'b0, Q0, "pulse4_wait");
    step(1'b0, 1'b1, 1'b1, 1'b0, RISE, "pulse4_rise");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, Q1, "pulse4_high");
    step(1'b0, 1'b1, 1'b1, 1'b0, FALL, "pulse4_fall");
    step(1'b0, 1'b1, 1'b1, 1'b0, Q0, "pulse4_low");

    // Local driver active with a toggling echo, then release with I held high
    for (int k = 0; k < 10; k++) step((k % 2 == 0), 1'b0, 1'b1, 1'b0, Q0, "blank_echo");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q0, "blank_tail");
    step(1'b1, 1'b1, 1'b1, 1'b0, RISE, "blank_rel_rise");
    step(1'b1, 1'b1, 1'b1, 1'b0, Q1, "blank_rel_hold");

    // Freeze with fcnt=2, then exactly two more enabled edges to the fall
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, Q1, "ce_pre");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, Q1, "ce_freeze");
    step(1'b0, 1'b1, 1'b1, 1'b0, Q1, "ce_resume");
    step(1'b0, 1'b1, 1'b1, 1'b0, FALL, "ce_fall");
    step(1'b0, 1'b1, 1'b1, 1'b0, Q0, "ce_post");

    // Reset lands where fcnt=3 and icnt=10; the edge would otherwise rise O
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, Q0, "rst_pre");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q0, "rst_pre_filt");
    step(1'b1, 1'b1, 1'b1, 1'b1, Q0, "rst_mid");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0, Q0, "rst_restart");
    step(1'b1, 1'b1, 1'b1, 1'b0, RISE, "rst_restart_rise");
    step(1'b1, 1'b1, 1'b1, 1'b0, Q1, "rst_restart_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
